// File: rtl/io_mem_bridge.sv
// rtl/io_mem_bridge.sv - cpu data-port bridge: ram pass-through plus a memory-mapped I/O window
// Every read, ram or I/O, returns data one cycle later so the cpu sees uniform timing.
module io_mem_bridge #(
  parameter int                 g_DATA_WIDTH  = 9,
  parameter int                 g_ADDR_WIDTH  = 11,
  parameter int                 g_IO_WIN_BITS = 4,
  parameter int                 g_N_LED       = 8,
  parameter int                 g_N_SW        = 8,
  parameter int                 g_N_BTN       = 5,
  parameter logic [g_N_LED-1:0] g_LED_RESET   = 8'b10011001,
  parameter int                 g_PRESCALE    = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cpu_en,
  input  logic                    i_cpu_we,
  input  logic                    i_cpu_re,
  input  logic [g_ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [g_DATA_WIDTH-1:0] i_cpu_data,
  output logic [g_DATA_WIDTH-1:0] o_cpu_data,
  output logic                    o_ram_en,
  output logic                    o_ram_we,
  output logic                    o_ram_re,
  output logic [g_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [g_DATA_WIDTH-1:0] o_ram_data,
  input  logic [g_DATA_WIDTH-1:0] i_ram_data,
  output logic [g_N_LED-1:0]      o_led,
  input  logic [g_N_SW-1:0]       i_sw,
  input  logic [g_N_BTN-1:0]      i_btn,
  output logic                    o_irq
);

  localparam int                c_PW         = (g_PRESCALE > 1) ? $clog2(g_PRESCALE) : 1;
  localparam logic [c_PW-1:0]   c_PRESC_LAST = c_PW'(g_PRESCALE - 1);

  logic                    io_sel, io_wr, io_rd;
  logic [2:0]              off;
  logic [g_DATA_WIDTH-1:0] rd_val;

  logic [g_N_LED-1:0]      led_q, led_d;
  logic [g_N_SW-1:0]       sw_meta_q, sw_sync_q;
  logic [g_N_BTN-1:0]      btn_meta_q, btn_sync_q, btn_prev_q;
  logic [g_N_BTN-1:0]      edge_q, edge_d, edge_clr;
  logic [g_N_BTN-1:0]      irq_en_q, irq_en_d;
  logic                    irq_q;
  logic [c_PW-1:0]         presc_q, presc_d;
  logic [g_DATA_WIDTH-1:0] tick_q, tick_d;
  logic                    rd_src_q, rd_src_d;
  logic [g_DATA_WIDTH-1:0] rd_q, rd_d;

  assign io_sel = i_cpu_en & (&i_cpu_addr[g_ADDR_WIDTH-1 -: g_IO_WIN_BITS]);
  assign io_wr  = io_sel & i_cpu_we;
  assign io_rd  = io_sel & i_cpu_re;
  assign off    = i_cpu_addr[2:0];

  assign o_ram_en   = i_cpu_en & ~io_sel;
  assign o_ram_we   = i_cpu_en & ~io_sel & i_cpu_we;
  assign o_ram_re   = i_cpu_en & ~io_sel & i_cpu_re;
  assign o_ram_addr = i_cpu_addr;
  assign o_ram_data = i_cpu_data;

  assign o_cpu_data = rd_src_q ? rd_q : i_ram_data;
  assign o_led      = led_q;
  assign o_irq      = irq_q;

  // Read value is taken from the current registers, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (off)
      3'd0:    rd_val[g_N_LED-1:0] = led_q;
      3'd1:    rd_val[g_N_SW-1:0]  = sw_sync_q;
      3'd2:    rd_val[g_N_BTN-1:0] = btn_sync_q;
      3'd3:    rd_val[g_N_BTN-1:0] = edge_q;
      3'd4:    rd_val[g_N_BTN-1:0] = irq_en_q;
      3'd5:    rd_val              = tick_q;
      default: rd_val              = '0;
    endcase
  end

  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;
    if (io_wr && off == 3'd0) led_d    = i_cpu_data[g_N_LED-1:0];
    if (io_wr && off == 3'd4) irq_en_d = i_cpu_data[g_N_BTN-1:0];
    if (io_wr && off == 3'd3) edge_clr = i_cpu_data[g_N_BTN-1:0];
    // A fresh edge is ORed in after the clear so it cannot be lost.
    edge_d = (edge_q & ~edge_clr) | (btn_sync_q & ~btn_prev_q);

    presc_d = presc_q + c_PW'(1);
    tick_d  = tick_q;
    if (io_wr && off == 3'd5) begin
      presc_d = '0;
      tick_d  = '0;
    end else if (presc_q == c_PRESC_LAST) begin
      presc_d = '0;
      tick_d  = tick_q + g_DATA_WIDTH'(1);
    end

    rd_src_d = (i_cpu_en && i_cpu_re) ? io_sel : rd_src_q;
    rd_d     = io_rd ? rd_val : rd_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q      <= g_LED_RESET;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      edge_q     <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      presc_q    <= '0;
      tick_q     <= '0;
      rd_src_q   <= 1'b0;
      rd_q       <= '0;
    end else begin
      led_q      <= led_d;
      sw_meta_q  <= i_sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= i_btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      edge_q     <= edge_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(edge_q & irq_en_q);
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      rd_src_q   <= rd_src_d;
      rd_q       <= rd_d;
    end
  end

endmodule

// File: tb/tb_io_mem_bridge.sv
// tb/tb_io_mem_bridge.sv - scoreboard bench for io_mem_bridge with a behavioural register/ram model
module tb_io_mem_bridge;
  localparam int P = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_en, cpu_we, cpu_re;
  logic [10:0] cpu_addr;
  logic [8:0]  cpu_wdata, cpu_rdata;
  logic        ram_en, ram_we, ram_re;
  logic [10:0] ram_addr;
  logic [8:0]  ram_wdata, ram_rdata;
  logic [7:0]  led, sw;
  logic [4:0]  btn;
  logic        irq;

  io_mem_bridge #(.g_PRESCALE(P)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_en(cpu_en), .i_cpu_we(cpu_we), .i_cpu_re(cpu_re),
    .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_wdata), .o_cpu_data(cpu_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re),
    .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .i_ram_data(ram_rdata),
    .o_led(led), .i_sw(sw), .i_btn(btn), .o_irq(irq)
  );

  // Synchronous ram attached to the bridge, read-before-write.
  logic [8:0] ram_arr [0:2047];
  always @(posedge clk or posedge rst)
    if (rst) ram_rdata <= '0;
    else if (ram_en && ram_re) ram_rdata <= ram_arr[ram_addr];
  always @(posedge clk)
    if (!rst && ram_en && ram_we) ram_arr[ram_addr] <= ram_wdata;

  // Reference model state.
  logic [8:0] mram [0:2047];
  logic [7:0] m_led;
  logic [4:0] m_edge, m_irq_en;
  logic       m_irq;
  int         m_n;
  logic [7:0] swh [0:1];
  logic [4:0] bh  [0:2];

  logic [8:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;
  logic       rd_seen = 1'b0;
  logic       mon_io;
  logic [22:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_reg(input logic [2:0] off);
    case (off)
      3'd0:    return {1'b0, m_led};
      3'd1:    return {1'b0, swh[1]};
      3'd2:    return {4'b0, bh[1]};
      3'd3:    return {4'b0, m_edge};
      3'd4:    return {4'b0, m_irq_en};
      3'd5:    return 9'((m_n / P) % 512);
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_edge(input logic en, input logic we, input logic [10:0] a, input logic [8:0] d);
    logic       io;
    logic [4:0] rise;
    io   = (a >= 11'h780);
    rise = bh[1] & ~bh[2];
    m_irq = |(m_edge & m_irq_en);
    if (en && we && !io) mram[a] = d;
    if (en && we && io) begin
      case (a[2:0])
        3'd0:    m_led    = d[7:0];
        3'd3:    m_edge   = m_edge & ~d[4:0];
        3'd4:    m_irq_en = d[4:0];
        default: ;
      endcase
    end
    m_edge = m_edge | rise;
    m_n    = (en && we && io && a[2:0] == 3'd5) ? 0 : m_n + 1;
    swh[1] = swh[0]; swh[0] = sw;
    bh[2]  = bh[1];  bh[1]  = bh[0]; bh[0] = btn;
  endtask

  task automatic step(input logic en, input logic we, input logic re, input logic [10:0] a, input logic [8:0] d);
    cpu_en = en; cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
    if (en && re) exp_q.push_back((a >= 11'h780) ? m_reg(a[2:0]) : mram[a]);
    @(posedge clk);
    model_edge(en, we, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 11'h000, 9'h000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    m_led = 8'h99; m_edge = '0; m_irq_en = '0; m_irq = 1'b0; m_n = 0;
    swh[0] = '0; swh[1] = '0; bh[0] = '0; bh[1] = '0; bh[2] = '0;
    #1;
    chk("rst_cpu_data", 32'(cpu_rdata), 32'h0);
    chk("rst_led", 32'(led), 32'h99);
    chk("rst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per issued read and checks ram gating and register outputs.
  always @(posedge clk) rd_seen <= !rst && cpu_en && cpu_re;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_data act=%0h exp=none", cpu_rdata);
        end else begin
          chk("rd_data", 32'(cpu_rdata), 32'(exp_q.pop_front()));
        end
      end
      mon_io  = (cpu_addr >= 11'h780);
      mon_exp = {cpu_en & ~mon_io, cpu_en & cpu_we & ~mon_io, cpu_en & cpu_re & ~mon_io, cpu_addr, cpu_wdata};
      chk("ram_ctl", 32'({ram_en, ram_we, ram_re, ram_addr, ram_wdata}), 32'(mon_exp));
      chk("led", 32'(led), 32'(m_led));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; sw = '0; btn = '0;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #2;
    do_reset();
    step(1, 0, 1, 11'h785, 9'h000);

    // ram write/read and LED write
    step(1, 1, 0, 11'h010, 9'h155);
    step(1, 0, 1, 11'h010, 9'h000);
    step(1, 1, 0, 11'h780, 9'h0AA);
    idle(1);
    chk("led_aa", 32'(led), 32'hAA);

    // switches through the synchroniser, back-to-back ram/I-O reads
    sw = 8'h5A;
    idle(3);
    step(1, 0, 1, 11'h781, 9'h000);
    step(1, 0, 1, 11'h010, 9'h000);
    step(1, 0, 1, 11'h781, 9'h000);
    idle(1);

    // button edge, interrupt, clear, and edge racing the clear
    step(1, 1, 0, 11'h784, 9'h004);
    btn = 5'b00100; idle(2); btn = 5'b00000; idle(3);
    chk("irq_set", 32'(irq), 32'h1);
    step(1, 0, 1, 11'h783, 9'h000);
    step(1, 1, 0, 11'h783, 9'h004);
    idle(2);
    chk("irq_clr", 32'(irq), 32'h0);
    btn = 5'b00100; idle(2);
    step(1, 1, 0, 11'h783, 9'h004);
    idle(1);
    chk("edge_wins_irq", 32'(irq), 32'h1);
    step(1, 0, 1, 11'h783, 9'h000);
    btn = 5'b00000; idle(3);
    step(1, 1, 0, 11'h783, 9'h01F);
    idle(2);

    // tick counter: 17 cycles, clear on increment, wrap
    do_reset();
    idle(17);
    step(1, 0, 1, 11'h785, 9'h000);
    while (m_n % P != P - 1) idle(1);
    step(1, 1, 0, 11'h785, 9'h000);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 11'h785, 9'h000);
    while (m_n < 2044) idle(1);
    step(1, 0, 1, 11'h785, 9'h000);
    while (m_n < 2048) idle(1);
    step(1, 0, 1, 11'h785, 9'h000);

    // randomized traffic over a preloaded ram region and the whole I/O window
    for (int i = 0; i < 32; i++) step(1, 1, 0, 11'(i), 9'($urandom));
    step(1, 1, 0, 11'h77F, 9'($urandom));
    for (int i = 0; i < 400; i++) begin
      logic [10:0] a;
      int          k;
      k = int'($urandom_range(0, 9));
      if (k == 0)     a = 11'h77F;
      else if (k < 4) a = 11'($urandom_range(0, 31));
      else            a = 11'h780 | 11'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) sw  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) btn = 5'($urandom);
      step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), a, 9'($urandom));
    end

    // reset in the middle of an I/O read
    btn = 5'b00000; idle(3);
    btn = 5'b00010; idle(4);
    step(1, 0, 1, 11'h780, 9'h000);
    do_reset();
    step(1, 0, 1, 11'h783, 9'h000);
    step(1, 0, 1, 11'h780, 9'h000);
    idle(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
